// File: rtl/mem_bus_march_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_march_initiator
// Description : Drives the CPU data-memory bus in place of the CPU and runs a
//               march test (W0 up, R0W1 up, R1W0 down, R0 up) over the
//               address window [ADDR_LO, ADDR_HI]. Stops on the first
//               mismatch and reports the address, expected and read values.
// Ports       : clk        system clock (posedge)
//               res        synchronous active-high reset
//               start      level request, sampled only while idle
//               bus_addr   bus address
//               bus_wdata  write data
//               bus_rdata  read data, valid the cycle after a read issue
//               bus_sel    chip select
//               bus_ld     1 = read, 0 = write (with bus_sel)
//               bus_clr    memory clear strobe
//               busy       test in progress (through the done cycle)
//               done       one-cycle end-of-test pulse
//               pass       result of the last completed test
//               fail_addr  address of first mismatch
//               fail_exp   expected value at first mismatch
//               fail_got   value read at first mismatch
// Revision    : 1.0  initial release
// ============================================================================
module mem_bus_march_initiator #(
  parameter int                ADDR_W  = 12,
  parameter int                DATA_W  = 16,
  parameter int                ADDR_LO = 2,
  parameter int                ADDR_HI = 63,
  parameter logic [DATA_W-1:0] PATTERN = 16'hA5A5
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_sel,
  output logic              bus_ld,
  output logic              bus_clr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got
);

  localparam logic [ADDR_W-1:0] C_LO  = ADDR_W'(ADDR_LO);
  localparam logic [ADDR_W-1:0] C_HI  = ADDR_W'(ADDR_HI);
  localparam logic [ADDR_W-1:0] C_ONE = ADDR_W'(1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CLR    = 4'd1;
  localparam logic [3:0] S_W0     = 4'd2;
  localparam logic [3:0] S_UP_ISS = 4'd3;
  localparam logic [3:0] S_UP_CHK = 4'd4;
  localparam logic [3:0] S_UP_WR  = 4'd5;
  localparam logic [3:0] S_DN_ISS = 4'd6;
  localparam logic [3:0] S_DN_CHK = 4'd7;
  localparam logic [3:0] S_DN_WR  = 4'd8;
  localparam logic [3:0] S_RD_ISS = 4'd9;
  localparam logic [3:0] S_RD_CHK = 4'd10;
  localparam logic [3:0] S_DONE   = 4'd11;

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              bus_sel_q, bus_sel_d;
  logic              bus_ld_q, bus_ld_d;
  logic              bus_clr_q, bus_clr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
  logic [DATA_W-1:0] fail_got_q, fail_got_d;

  logic              w_is_chk;
  logic [DATA_W-1:0] w_chk_exp;
  logic              w_mismatch;

  // The descending phase expects the complement; the others expect P.
  assign w_is_chk   = (state_q == S_UP_CHK) || (state_q == S_DN_CHK) ||
                      (state_q == S_RD_CHK);
  assign w_chk_exp  = (state_q == S_DN_CHK) ? ~PATTERN : PATTERN;
  assign w_mismatch = w_is_chk && (bus_rdata != w_chk_exp);

  // --------------------------------------------------------------------------
  // State register (state, address counter and all registered outputs)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= 1'b0;
      bus_ld_q    <= 1'b1;
      bus_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      bus_ld_q    <= bus_ld_d;
      bus_clr_q   <= bus_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_got_q  <= fail_got_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Phase ends are detected by comparing against the bound,
  // so the counter never relies on wrap-around and N=1 windows work.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          addr_d  = C_LO;
        end
      end
      S_CLR: begin
        state_d = S_W0;
        addr_d  = C_LO;
      end
      S_W0: begin
        if (addr_q == C_HI) begin
          state_d = S_UP_ISS;
          addr_d  = C_LO;
        end else begin
          addr_d  = addr_q + C_ONE;
        end
      end
      S_UP_ISS: state_d = S_UP_CHK;
      S_UP_CHK: state_d = w_mismatch ? S_DONE : S_UP_WR;
      S_UP_WR: begin
        // Turn around at the top: the descending pass starts at ADDR_HI.
        if (addr_q == C_HI) begin
          state_d = S_DN_ISS;
        end else begin
          state_d = S_UP_ISS;
          addr_d  = addr_q + C_ONE;
        end
      end
      S_DN_ISS: state_d = S_DN_CHK;
      S_DN_CHK: state_d = w_mismatch ? S_DONE : S_DN_WR;
      S_DN_WR: begin
        if (addr_q == C_LO) begin
          state_d = S_RD_ISS;
        end else begin
          state_d = S_DN_ISS;
          addr_d  = addr_q - C_ONE;
        end
      end
      S_RD_ISS: state_d = S_RD_CHK;
      S_RD_CHK: begin
        if (w_mismatch || (addr_q == C_HI)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD_ISS;
          addr_d  = addr_q + C_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. Bus outputs are computed from the next state so that the
  // registered outputs line up with the state they belong to.
  // --------------------------------------------------------------------------
  always_comb begin
    bus_sel_d   = 1'b0;
    bus_ld_d    = 1'b1;
    bus_clr_d   = 1'b0;
    bus_wdata_d = '0;
    bus_addr_d  = '0;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_got_d  = fail_got_q;

    case (state_d)
      S_CLR: bus_clr_d = 1'b1;
      S_W0: begin
        bus_sel_d   = 1'b1;
        bus_ld_d    = 1'b0;
        bus_wdata_d = PATTERN;
        bus_addr_d  = addr_d;
      end
      S_UP_ISS, S_DN_ISS, S_RD_ISS: begin
        bus_sel_d  = 1'b1;
        bus_addr_d = addr_d;
      end
      S_UP_CHK, S_DN_CHK, S_RD_CHK: bus_addr_d = addr_d;
      S_UP_WR: begin
        bus_sel_d   = 1'b1;
        bus_ld_d    = 1'b0;
        bus_wdata_d = ~PATTERN;
        bus_addr_d  = addr_d;
      end
      S_DN_WR: begin
        bus_sel_d   = 1'b1;
        bus_ld_d    = 1'b0;
        bus_wdata_d = PATTERN;
        bus_addr_d  = addr_d;
      end
      default: ;
    endcase

    // Result registers: cleared on accept, captured on first mismatch,
    // and pass set only when the final read of the last phase is clean.
    if ((state_q == S_IDLE) && start) begin
      pass_d      = 1'b0;
      fail_addr_d = '0;
      fail_exp_d  = '0;
      fail_got_d  = '0;
    end
    if (w_mismatch) begin
      fail_addr_d = addr_q;
      fail_exp_d  = w_chk_exp;
      fail_got_d  = bus_rdata;
    end else if ((state_q == S_RD_CHK) && (addr_q == C_HI)) begin
      pass_d = 1'b1;
    end
  end

  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_sel   = bus_sel_q;
  assign bus_ld    = bus_ld_q;
  assign bus_clr   = bus_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_got  = fail_got_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_march_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_march_initiator
// Description : Self-checking bench for mem_bus_march_initiator. A RAM
//               responder with optional stuck-at / coupling faults answers
//               the bus; a march reference model predicts the bus trace,
//               the done cycle and the reported result.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_march_initiator;

  localparam int          LO = 2;
  localparam int          HI = 63;
  localparam int          N  = HI - LO + 1;
  localparam logic [15:0] P  = 16'hA5A5;

  logic        clk = 1'b0;
  logic        res;
  logic        start;
  logic [11:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata = 16'h0;
  logic        bus_sel, bus_ld, bus_clr, busy, done, pass;
  logic [11:0] fail_addr;
  logic [15:0] fail_exp, fail_got;

  logic        start6;
  logic [11:0] bus_addr6;
  logic [15:0] bus_wdata6;
  logic [15:0] bus_rdata6 = 16'h0;
  logic        bus_sel6, bus_ld6, bus_clr6, busy6, done6, pass6;
  logic [11:0] fail_addr6;
  logic [15:0] fail_exp6, fail_got6;

  always #5 clk = ~clk;

  mem_bus_march_initiator dut (
    .clk(clk), .res(res), .start(start),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_sel(bus_sel), .bus_ld(bus_ld), .bus_clr(bus_clr),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got)
  );

  mem_bus_march_initiator #(.ADDR_LO(5), .ADDR_HI(5)) dut6 (
    .clk(clk), .res(res), .start(start6),
    .bus_addr(bus_addr6), .bus_wdata(bus_wdata6), .bus_rdata(bus_rdata6),
    .bus_sel(bus_sel6), .bus_ld(bus_ld6), .bus_clr(bus_clr6),
    .busy(busy6), .done(done6), .pass(pass6),
    .fail_addr(fail_addr6), .fail_exp(fail_exp6), .fail_got(fail_got6)
  );

  // Fault configuration: 0 = ideal, 1 = stuck bit at f_addr, 2 = write to
  // f_addr also writes f_addr+1.
  int   f_kind = 0;
  int   f_addr = 0;
  int   f_bit  = 0;
  logic f_val  = 1'b0;

  // RAM responder for the main instance
  logic [15:0] ram  [0:4095];
  logic [15:0] rv;
  always @(posedge clk) begin
    if (bus_clr) begin
      for (int i = 0; i < 4096; i++) ram[i] = 16'h0;
    end else if (bus_sel && !bus_ld) begin
      ram[bus_addr] = bus_wdata;
      if (f_kind == 2 && int'(bus_addr) == f_addr) ram[int'(bus_addr) + 1] = bus_wdata;
    end
    if (bus_sel && bus_ld) begin
      rv = ram[bus_addr];
      if (f_kind == 1 && int'(bus_addr) == f_addr) rv[f_bit] = f_val;
      bus_rdata <= rv;
    end
  end

  // Ideal responder for the single-address instance
  logic [15:0] ram6 [0:4095];
  always @(posedge clk) begin
    if (bus_clr6) begin
      for (int i = 0; i < 4096; i++) ram6[i] = 16'h0;
    end else if (bus_sel6 && !bus_ld6) begin
      ram6[bus_addr6] = bus_wdata6;
    end
    if (bus_sel6 && bus_ld6) bus_rdata6 <= ram6[bus_addr6];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: the march algorithm on a plain array with the same fault
  // rules, emitting each selected bus cycle with its cycle number counted
  // from the start-accept edge (CLR is cycle 1).
  // --------------------------------------------------------------------------
  typedef struct {
    int          cyc;
    logic        ld;
    logic [11:0] addr;
    logic [15:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        act_q[$];
  logic [15:0] mm [0:4095];

  function automatic void mwr(input int a, input logic [15:0] v);
    mm[a] = v;
    if (f_kind == 2 && a == f_addr) mm[a + 1] = v;
  endfunction

  function automatic logic [15:0] mrd(input int a);
    logic [15:0] v;
    v = mm[a];
    if (f_kind == 1 && a == f_addr) v[f_bit] = f_val;
    return v;
  endfunction

  function automatic void push_exp(input int c, input logic ld, input int a, input logic [15:0] d);
    txn_t t;
    t.cyc = c; t.ld = ld; t.addr = 12'(a); t.wdata = d;
    exp_q.push_back(t);
  endfunction

  task automatic model_run(output logic m_pass, output logic [11:0] m_fa,
                           output logic [15:0] m_fe, output logic [15:0] m_fg,
                           output int m_done);
    int          a, c;
    logic [15:0] g;
    exp_q.delete();
    for (int i = 0; i < 4096; i++) mm[i] = 16'h0;
    m_pass = 1'b0; m_fa = '0; m_fe = '0; m_fg = '0;
    for (int j = 0; j < N; j++) begin
      push_exp(2 + j, 1'b0, LO + j, P);
      mwr(LO + j, P);
    end
    for (int j = 0; j < N; j++) begin
      a = LO + j; c = 2 + N + 3 * j;
      push_exp(c, 1'b1, a, 16'h0);
      g = mrd(a);
      if (g !== P) begin
        m_fa = 12'(a); m_fe = P; m_fg = g; m_done = c + 2; return;
      end
      push_exp(c + 2, 1'b0, a, ~P);
      mwr(a, ~P);
    end
    for (int k = 0; k < N; k++) begin
      a = HI - k; c = 2 + 4 * N + 3 * k;
      push_exp(c, 1'b1, a, 16'h0);
      g = mrd(a);
      if (g !== ~P) begin
        m_fa = 12'(a); m_fe = ~P; m_fg = g; m_done = c + 2; return;
      end
      push_exp(c + 2, 1'b0, a, P);
      mwr(a, P);
    end
    for (int j = 0; j < N; j++) begin
      a = LO + j; c = 2 + 7 * N + 2 * j;
      push_exp(c, 1'b1, a, 16'h0);
      g = mrd(a);
      if (g !== P) begin
        m_fa = 12'(a); m_fe = P; m_fg = g; m_done = c + 2; return;
      end
    end
    m_pass = 1'b1;
    m_done = 2 + 9 * N;
  endtask

  // --------------------------------------------------------------------------
  // One complete run against the main instance, with bus monitoring.
  // --------------------------------------------------------------------------
  task automatic run_test(input string tag, input bit hold, input logic e_pass,
                          input logic [11:0] e_fa, input logic [15:0] e_fe,
                          input logic [15:0] e_fg, input int e_done);
    int   act_done, proto_err, busy_err, clr_cnt, diff;
    logic prev_rd;
    txn_t t;
    act_q.delete();
    act_done = -1; proto_err = 0; busy_err = 0; clr_cnt = 0; prev_rd = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({tag, "_clear_on_start"}, {pass, fail_addr, fail_exp, fail_got}, 64'h0);
        if (!hold) start = 1'b0;
      end
      if (!busy) busy_err++;
      if (bus_clr) begin
        clr_cnt++;
        if (c != 1 || bus_sel) proto_err++;
      end
      if (bus_sel && (int'(bus_addr) < LO || int'(bus_addr) > HI)) proto_err++;
      if (prev_rd && bus_sel) proto_err++;
      prev_rd = bus_sel && bus_ld;
      if (bus_sel) begin
        t.cyc = c; t.ld = bus_ld; t.addr = bus_addr; t.wdata = bus_wdata;
        act_q.push_back(t);
      end
      if (done) begin
        act_done = c;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, 64'(act_done), 64'(e_done));
    chk({tag, "_pass"}, 64'(pass), 64'(e_pass));
    chk({tag, "_fail_addr"}, 64'(fail_addr), 64'(e_fa));
    chk({tag, "_fail_exp"}, 64'(fail_exp), 64'(e_fe));
    chk({tag, "_fail_got"}, 64'(fail_got), 64'(e_fg));
    chk({tag, "_protocol_errs"}, 64'(proto_err), 64'h0);
    chk({tag, "_busy_gaps"}, 64'(busy_err), 64'h0);
    chk({tag, "_clr_cycles"}, 64'(clr_cnt), 64'h1);
    diff = (act_q.size() == exp_q.size()) ? 0 : 1;
    if (diff == 0) begin
      for (int i = 0; i < act_q.size(); i++) begin
        if (act_q[i].cyc != exp_q[i].cyc || act_q[i].ld !== exp_q[i].ld ||
            act_q[i].addr !== exp_q[i].addr || act_q[i].wdata !== exp_q[i].wdata)
          diff++;
      end
    end
    chk({tag, "_bus_trace_diffs"}, 64'(diff), 64'h0);
    @(negedge clk);
    chk({tag, "_idle_after_done"}, {62'h0, busy, done}, 64'h0);
    chk({tag, "_pass_held"}, 64'(pass), 64'(e_pass));
  endtask

  typedef struct {
    string       name;
    int          kind;
    int          faddr;
    int          fbit;
    logic        fval;
    logic        e_pass;
    logic [11:0] e_fa;
    logic [15:0] e_fe;
    logic [15:0] e_fg;
    int          e_done;
  } vec_t;

  vec_t vecs[5];

  logic        m_pass;
  logic [11:0] m_fa;
  logic [15:0] m_fe, m_fg;
  int          m_done;
  int          tx6, win6, done6_cyc;

  initial begin
    vecs[0] = '{"ideal",      0,  0, 0, 1'b0, 1'b1, 12'd0,  16'h0000, 16'h0000, 560};
    vecs[1] = '{"stuck17b3",  1, 17, 3, 1'b0, 1'b0, 12'd17, 16'h5A5A, 16'h5A52, 390};
    vecs[2] = '{"couple40",   2, 40, 0, 1'b0, 1'b0, 12'd41, 16'hA5A5, 16'h5A5A, 183};
    vecs[3] = '{"stuck2b0",   1,  2, 0, 1'b1, 1'b0, 12'd2,  16'h5A5A, 16'h5A5B, 435};
    vecs[4] = '{"stuck63b1",  1, 63, 1, 1'b1, 1'b0, 12'd63, 16'hA5A5, 16'hA5A7, 249};

    res = 1'b1; start = 1'b0; start6 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_status", {busy, done, pass, fail_addr, fail_exp, fail_got}, 64'h0);
    chk("reset_bus", {bus_sel, bus_ld, bus_clr, bus_addr, bus_wdata}, {33'h0, 1'b0, 1'b1, 1'b0, 12'h0, 16'h0});
    res = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven fault scenarios
    for (int v = 0; v < 5; v++) begin
      f_kind = vecs[v].kind; f_addr = vecs[v].faddr;
      f_bit  = vecs[v].fbit; f_val  = vecs[v].fval;
      model_run(m_pass, m_fa, m_fe, m_fg, m_done);
      run_test(vecs[v].name, (v == 2), vecs[v].e_pass, vecs[v].e_fa,
               vecs[v].e_fe, vecs[v].e_fg, vecs[v].e_done);
    end

    // Randomized faults against the reference model
    for (int r = 0; r < 6; r++) begin
      f_kind = int'($urandom_range(0, 2));
      f_addr = int'($urandom_range(LO, HI - 1));
      f_bit  = int'($urandom_range(0, 15));
      f_val  = 1'($urandom_range(0, 1));
      model_run(m_pass, m_fa, m_fe, m_fg, m_done);
      run_test($sformatf("rand%0d_k%0d_a%0d", r, f_kind, f_addr), r[0],
               m_pass, m_fa, m_fe, m_fg, m_done);
    end

    // Reset in the middle of the descending phase
    f_kind = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2 + 4 * N + 10 - 1) @(negedge clk);
    chk("midrun_busy", {63'h0, busy}, 64'h1);
    res = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_reset_status", {busy, done, pass, fail_addr, fail_exp, fail_got}, 64'h0);
    chk("midrun_reset_bus", {bus_sel, bus_ld, bus_clr, bus_addr, bus_wdata}, {33'h0, 1'b0, 1'b1, 1'b0, 12'h0, 16'h0});
    res = 1'b0;
    tx6 = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) tx6++;
    end
    chk("midrun_stays_idle", 64'(tx6), 64'h0);
    model_run(m_pass, m_fa, m_fe, m_fg, m_done);
    run_test("restart", 1'b0, 1'b1, 12'd0, 16'h0, 16'h0, 560);

    // Single-address window
    tx6 = 0; win6 = 0; done6_cyc = -1;
    @(negedge clk);
    start6 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1) start6 = 1'b0;
      if (bus_sel6 || bus_clr6) tx6++;
      if (bus_sel6 && bus_addr6 != 12'd5) win6++;
      if (done6) begin
        done6_cyc = c;
        break;
      end
    end
    chk("n1_done_cycle", 64'(done6_cyc), 64'd11);
    chk("n1_transactions", 64'(tx6), 64'd7);
    chk("n1_window", 64'(win6), 64'd0);
    chk("n1_pass", 64'(pass6), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
